// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot-time byte-stream program loader for the instruction memory
//
// Accepts a big-endian stream: 16-bit word count N (high byte first), then
// N instruction words of four bytes each, MSB first. Each completed word is
// written to instruction memory at byte address 4*i, i = 0..N-1. The core is
// held in reset until the whole program has landed.
//
// Optional feature macro: LOADER_CHECKSUM_EN. When defined, one extra byte
// follows the data and must equal the XOR of all 4N data bytes.
//
// Ports:
//   clk       system clock, rising edge
//   Reset     synchronous active-high reset
//   in_valid  stream byte valid
//   in_data   stream byte
//   in_ready  loader accepts a byte this cycle
//   wr_en     one-cycle instruction-memory write strobe
//   wr_addr   word-aligned byte address of the write
//   wr_data   instruction word to write
//   cpu_reset reset to PC/core, high until the load completes
//   done      load completed (sticky until Reset)
//   error     load aborted (sticky until Reset)
module instr_loader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam int IW = $clog2(DEPTH) + 1;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CHK,
        DONE,
        ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     len_q, len_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [23:0]     word_q, word_d;
    logic [7:0]      csum_q, csum_d;
    logic            in_ready_q, in_ready_d;
    logic            wr_en_q, wr_en_d;
    logic [31:0]     wr_addr_q, wr_addr_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic            cpu_reset_q, cpu_reset_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic            accept;
    logic [15:0]     len_full;

    // in_ready is registered, so a transfer is judged against the value the
    // upstream saw this cycle.
    assign accept   = in_valid && in_ready_q;
    assign len_full = {len_q[15:8], in_data};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        word_d    = word_q;
        csum_d    = csum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;

        case (state_q)
            LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d  = len_full;
                    idx_d  = '0;
                    bcnt_d = '0;
                    csum_d = '0;
                    if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
`endif
                    end else if (len_full > DEPTH16) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    word_d = {word_q[15:0], in_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {{(32-IW-2){1'b0}}, idx_q, 2'b00};
                        wr_data_d = {word_q, in_data};
                        idx_d     = idx_q + 1'b1;
                        bcnt_d    = 2'd0;
                        if ({{(16-IW){1'b0}}, idx_q} + 16'd1 == len_q) begin
                            // done is deliberately not raised on this edge:
                            // it follows one cycle after the final write.
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = DONE;
`endif
                        end
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            ERROR: begin
            end
            default: begin
                state_d = ERROR;
            end
        endcase

        in_ready_d  = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                      (state_d == DATA)   || (state_d == CHK);
        error_d     = (state_d == ERROR);
        cpu_reset_d = !done_d;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= LEN_HI;
            len_q       <= '0;
            idx_q       <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            bcnt_q      <= bcnt_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
